// File: rtl/mac_seq_pkg.sv
// Shared definitions for the MAC sequencer.
// Contents: engine mode codes, the sequencer state encoding and a
// legality check for the command mode field.
package mac_seq_pkg;

  localparam logic [3:0] MODE_2B = 4'd0;
  localparam logic [3:0] MODE_4B = 4'd1;
  localparam logic [3:0] MODE_8B = 4'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_WAIT_V,
    ST_XFER,
    ST_GAP
  } state_t;

  // Mode codes are dense from 0, so anything above the widest mode is illegal.
  function automatic logic mode_legal(input logic [3:0] mode);
    return (mode <= MODE_8B);
  endfunction

endpackage

// File: rtl/mac_sequencer_if.sv
// Bundle of every handshake/bus signal around the MAC sequencer.
// Groups: command port (host -> sequencer), operand memory read port,
// engine control/operand/result port, downstream result stream and
// done/err status pulses.
// Modports: slave  = the sequencer itself
//           master = the surrounding system (host, memories, engine, sink)
interface mac_sequencer_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10,
  parameter int SUM_W  = 20,
  parameter int CNT_W  = 8
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [3:0]        cmd_mode;
  logic              cmd_sx;
  logic              cmd_sy;
  logic [CNT_W-1:0]  cmd_len;
  logic [CNT_W-1:0]  cmd_count;
  logic [ADDR_W-1:0] cmd_act_base;
  logic [ADDR_W-1:0] cmd_wgt_base;

  logic              mem_rd_en;
  logic [ADDR_W-1:0] act_addr;
  logic [ADDR_W-1:0] wgt_addr;
  logic [DATA_W-1:0] act_rdata;
  logic [DATA_W-1:0] wgt_rdata;

  logic              eng_en;
  logic [DATA_W-1:0] eng_act;
  logic [DATA_W-1:0] eng_wgt;
  logic [3:0]        eng_mode;
  logic              eng_sx;
  logic              eng_sy;
  logic [CNT_W-1:0]  eng_batch_size;
  logic              eng_valid;
  logic              eng_ready;
  logic [SUM_W-1:0]  eng_sum;

  logic              res_valid;
  logic              res_ready;
  logic [SUM_W-1:0]  res_data;
  logic              res_last;

  logic              done;
  logic              err;

  modport slave (
    input  cmd_valid, cmd_mode, cmd_sx, cmd_sy, cmd_len, cmd_count,
           cmd_act_base, cmd_wgt_base, act_rdata, wgt_rdata,
           eng_valid, eng_sum, res_ready,
    output cmd_ready, mem_rd_en, act_addr, wgt_addr, eng_en, eng_act,
           eng_wgt, eng_mode, eng_sx, eng_sy, eng_batch_size, eng_ready,
           res_valid, res_data, res_last, done, err
  );

  modport master (
    output cmd_valid, cmd_mode, cmd_sx, cmd_sy, cmd_len, cmd_count,
           cmd_act_base, cmd_wgt_base, act_rdata, wgt_rdata,
           eng_valid, eng_sum, res_ready,
    input  cmd_ready, mem_rd_en, act_addr, wgt_addr, eng_en, eng_act,
           eng_wgt, eng_mode, eng_sx, eng_sy, eng_batch_size, eng_ready,
           res_valid, res_data, res_last, done, err
  );

endinterface

// File: rtl/mac_seq_addr_gen.sv
// Operand address generator for the MAC sequencer.
// Ports: clk, rst (async, active-high)
//        load     - start of job: both pointers take their bases, elem=0
//        step     - one operand read issued: pointers and elem advance
//        restart  - between dot products: activation pointer rewinds to
//                   its base, weight pointer keeps going (next row), elem=0
//        act_base, wgt_base - bases sampled on load
//        len      - elements per dot product (latched job length)
//        act_ptr, wgt_ptr   - current read addresses
//        last_elem          - current element is the last of the row
// Pointers wrap modulo 2^ADDR_W by plain overflow.
module mac_seq_addr_gen #(
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic              restart,
  input  logic [ADDR_W-1:0] act_base,
  input  logic [ADDR_W-1:0] wgt_base,
  input  logic [CNT_W-1:0]  len,
  output logic [ADDR_W-1:0] act_ptr,
  output logic [ADDR_W-1:0] wgt_ptr,
  output logic              last_elem
);

  logic [ADDR_W-1:0] act_ptr_reg;
  logic [ADDR_W-1:0] act_base_reg;
  logic [ADDR_W-1:0] wgt_ptr_reg;
  logic [CNT_W-1:0]  elem_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_ptr_reg  <= '0;
      act_base_reg <= '0;
      wgt_ptr_reg  <= '0;
      elem_reg     <= '0;
    end else if (load) begin
      act_ptr_reg  <= act_base;
      act_base_reg <= act_base;
      wgt_ptr_reg  <= wgt_base;
      elem_reg     <= '0;
    end else if (step) begin
      act_ptr_reg  <= act_ptr_reg + ADDR_W'(1);
      wgt_ptr_reg  <= wgt_ptr_reg + ADDR_W'(1);
      elem_reg     <= elem_reg + CNT_W'(1);
    end else if (restart) begin
      // Activation vector is reused for every row; weights stream on.
      act_ptr_reg  <= act_base_reg;
      elem_reg     <= '0;
    end
  end

  assign act_ptr   = act_ptr_reg;
  assign wgt_ptr   = wgt_ptr_reg;
  assign last_elem = (elem_reg == len - CNT_W'(1));

endmodule

// File: rtl/mac_sequencer.sv
// Command-driven controller for one mac_engine.
// Ports: clk, rst (async, active-high), bus (mac_sequencer_if.slave).
// A job runs cmd_count dot products of cmd_len elements in matrix-vector
// order: the activation vector is re-read for every row while weight
// addresses advance continuously. Each engine result is captured and
// offered on the res_* stream; done pulses after the last one is taken,
// err pulses when a command is rejected.
module mac_sequencer
  import mac_seq_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10,
  parameter int SUM_W  = 20,
  parameter int CNT_W  = 8
) (
  input logic             clk,
  input logic             rst,
  mac_sequencer_if.slave  bus
);

  state_t            state_reg;
  logic              cmd_ready_reg;
  logic              mem_rd_en_reg;
  logic              rd_en_d_reg;
  logic              eng_en_reg;
  logic [3:0]        mode_reg;
  logic              sx_reg;
  logic              sy_reg;
  logic [CNT_W-1:0]  len_reg;
  logic [CNT_W-1:0]  count_reg;
  logic [CNT_W-1:0]  outs_reg;
  logic              res_valid_reg;
  logic              res_last_reg;
  logic [SUM_W-1:0]  res_data_reg;
  logic              done_reg;
  logic              err_reg;

  logic              cmd_accept;
  logic              cmd_bad;
  logic              job_start;
  logic              last_elem;
  logic              res_fire;
  logic [ADDR_W-1:0] act_ptr;
  logic [ADDR_W-1:0] wgt_ptr;
  logic [1:0][DATA_W-1:0] rdata;
  logic [1:0][DATA_W-1:0] gated;

  assign cmd_accept = cmd_ready_reg && bus.cmd_valid;
  assign cmd_bad    = !mode_legal(bus.cmd_mode) || (bus.cmd_len == '0);
  assign job_start  = cmd_accept && !cmd_bad && (bus.cmd_count != '0);
  assign res_fire   = res_valid_reg && bus.res_ready;

  mac_seq_addr_gen #(
    .ADDR_W (ADDR_W),
    .CNT_W  (CNT_W)
  ) u_addr_gen (
    .clk       (clk),
    .rst       (rst),
    .load      (job_start),
    .step      (state_reg == ST_RUN),
    .restart   (state_reg == ST_GAP),
    .act_base  (bus.cmd_act_base),
    .wgt_base  (bus.cmd_wgt_base),
    .len       (len_reg),
    .act_ptr   (act_ptr),
    .wgt_ptr   (wgt_ptr),
    .last_elem (last_elem)
  );

  // Read data is only meaningful the cycle after a strobe; otherwise the
  // memory output may still hold a stale word, so it is forced to zero.
  assign rdata = {bus.wgt_rdata, bus.act_rdata};
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_opnd
      assign gated[gi] = rd_en_d_reg ? rdata[gi] : '0;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      cmd_ready_reg <= 1'b1;
      mem_rd_en_reg <= 1'b0;
      rd_en_d_reg   <= 1'b0;
      eng_en_reg    <= 1'b0;
      mode_reg      <= '0;
      sx_reg        <= 1'b0;
      sy_reg        <= 1'b0;
      len_reg       <= '0;
      count_reg     <= '0;
      outs_reg      <= '0;
      res_valid_reg <= 1'b0;
      res_last_reg  <= 1'b0;
      res_data_reg  <= '0;
      done_reg      <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      done_reg    <= 1'b0;
      err_reg     <= 1'b0;
      rd_en_d_reg <= mem_rd_en_reg;
      case (state_reg)
        ST_IDLE: begin
          if (cmd_accept) begin
            if (cmd_bad) begin
              err_reg <= 1'b1;
            end else if (bus.cmd_count == '0) begin
              done_reg <= 1'b1;
            end else begin
              mode_reg      <= bus.cmd_mode;
              sx_reg        <= bus.cmd_sx;
              sy_reg        <= bus.cmd_sy;
              len_reg       <= bus.cmd_len;
              count_reg     <= bus.cmd_count;
              outs_reg      <= '0;
              cmd_ready_reg <= 1'b0;
              eng_en_reg    <= 1'b1;
              mem_rd_en_reg <= 1'b1;
              state_reg     <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (last_elem) begin
            mem_rd_en_reg <= 1'b0;
            state_reg     <= ST_WAIT_V;
          end
        end
        ST_WAIT_V: begin
          if (bus.eng_valid) begin
            res_data_reg  <= bus.eng_sum;
            res_valid_reg <= 1'b1;
            res_last_reg  <= (outs_reg == count_reg - CNT_W'(1));
            state_reg     <= ST_XFER;
          end
        end
        ST_XFER: begin
          if (res_fire) begin
            outs_reg      <= outs_reg + CNT_W'(1);
            res_valid_reg <= 1'b0;
            res_last_reg  <= 1'b0;
            eng_en_reg    <= 1'b0;
            if (res_last_reg) begin
              done_reg      <= 1'b1;
              cmd_ready_reg <= 1'b1;
              state_reg     <= ST_IDLE;
            end else begin
              state_reg <= ST_GAP;
            end
          end
        end
        ST_GAP: begin
          // One idle engine cycle so it can clear before the next row.
          eng_en_reg    <= 1'b1;
          mem_rd_en_reg <= 1'b1;
          state_reg     <= ST_RUN;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.cmd_ready      = cmd_ready_reg;
  assign bus.mem_rd_en      = mem_rd_en_reg;
  assign bus.act_addr       = act_ptr;
  assign bus.wgt_addr       = wgt_ptr;
  assign bus.eng_en         = eng_en_reg;
  assign bus.eng_act        = gated[0];
  assign bus.eng_wgt        = gated[1];
  assign bus.eng_mode       = mode_reg;
  assign bus.eng_sx         = sx_reg;
  assign bus.eng_sy         = sy_reg;
  assign bus.eng_batch_size = len_reg;
  assign bus.eng_ready      = res_fire;
  assign bus.res_valid      = res_valid_reg;
  assign bus.res_data       = res_data_reg;
  assign bus.res_last       = res_last_reg;
  assign bus.done           = done_reg;
  assign bus.err            = err_reg;

endmodule
